// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states and
// the constants used for bubbles and word alignment.
package fetch_pkg;

   typedef enum logic [1:0] {
      START,
      FETCH,
      HOLD,
      DRAIN
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
   localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to a
// variable-latency instruction memory, parks words during stalls and handles redirects.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_f,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_f,
   output logic [31:0] pc_plus4_f,
   output logic        valid_f
);

   fetch_state_t r_state;
   fetch_state_t w_nextState;
   logic [31:0]  r_pc;
   logic [31:0]  w_nextPc;
   logic [31:0]  r_holdInstr;
   logic [31:0]  w_nextHoldInstr;
   logic [31:0]  r_reqAddr;
   logic [31:0]  w_nextReqAddr;
   logic [31:0]  w_pcPlus4;
   logic [31:0]  w_target;

   assign w_pcPlus4 = r_pc + 32'd4;
   assign w_target  = redirect_pc & WORD_ALIGN_MASK;

   // State register; reset also kills any request the memory still has open.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= START;
         r_pc        <= RESET_PC;
         r_holdInstr <= NOP_INSTR;
         r_reqAddr   <= RESET_PC;
      end else begin
         r_state     <= w_nextState;
         r_pc        <= w_nextPc;
         r_holdInstr <= w_nextHoldInstr;
         r_reqAddr   <= w_nextReqAddr;
      end
   end

   // Next-state and output decode; redirect beats stall, stall beats advance.
   always_comb begin
      w_nextState     = r_state;
      w_nextPc        = r_pc;
      w_nextHoldInstr = r_holdInstr;
      w_nextReqAddr   = r_reqAddr;
      imem_req        = 1'b0;
      imem_addr       = r_pc;
      instr_f         = NOP_INSTR;
      pc_plus4_f      = NOP_INSTR;
      valid_f         = 1'b0;

      case (r_state)
         START: begin
            w_nextState = FETCH;
         end

         FETCH: begin
            imem_req = 1'b1;
            if (redirect) begin
               w_nextPc = w_target;
               if (!imem_ack) begin
                  // The open request keeps its address until its ack is swallowed.
                  w_nextReqAddr = r_pc;
                  w_nextState   = DRAIN;
               end
            end else if (imem_ack) begin
               instr_f    = imem_rdata;
               pc_plus4_f = w_pcPlus4;
               valid_f    = 1'b1;
               if (stall_f) begin
                  w_nextHoldInstr = imem_rdata;
                  w_nextState     = HOLD;
               end else begin
                  w_nextPc = w_pcPlus4;
               end
            end
         end

         HOLD: begin
            if (redirect) begin
               w_nextPc    = w_target;
               w_nextState = FETCH;
            end else begin
               instr_f    = r_holdInstr;
               pc_plus4_f = w_pcPlus4;
               valid_f    = 1'b1;
               if (!stall_f) begin
                  w_nextPc    = w_pcPlus4;
                  w_nextState = FETCH;
               end
            end
         end

         DRAIN: begin
            imem_req  = 1'b1;
            imem_addr = r_reqAddr;
            if (redirect) begin
               w_nextPc = w_target;
            end
            if (imem_ack) begin
               w_nextState = FETCH;
            end
         end

         default: begin
            w_nextState = START;
         end
      endcase
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that produces the instruction word and PC+4 consumed by the decode pipeline register. Owns the PC, issues one-at-a-time requests to a variable-latency instruction memory, parks a fetched word while the hazard unit stalls fetch, and handles branch/jump redirects, including discarding an in-flight response. Bubbles are presented as all-zero instruction and PC+4 (MIPS `sll $0,$0,0`), matching the decode register's clear value.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall_f`  in  1  decode register not accepting this cycle; the presented instruction must be held.
- `redirect`  in  1  taken branch/jump resolved; PC must change to `redirect_pc`.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored and forced to 0.
- `imem_req`  out  1  request valid; held high with stable `imem_addr` until `imem_ack`.
- `imem_addr`  out  32  word-aligned fetch address (= current PC).
- `imem_ack`  in  1  single-cycle response strobe; `imem_rdata` valid in the same cycle.
- `imem_rdata`  in  32  instruction word.
- `instr_f`  out  32  instruction to decode register; 0 when `valid_f`=0.
- `pc_plus4_f`  out  32  PC+4 of `instr_f`; 0 when `valid_f`=0.
- `valid_f`  out  1  `instr_f`/`pc_plus4_f` hold a real instruction.

## Operation
- States: START, FETCH, HOLD, DRAIN. Registers: `pc`, `hold_instr`, state.
- START: `imem_req`=0, outputs bubble; next state FETCH unconditionally.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. Without ack: outputs bubble, stay.
  - ack, no redirect, no stall: `instr_f`=`imem_rdata` (combinational pass-through), `pc_plus4_f`=`pc`+4, `valid_f`=1; at edge `pc`<=`pc`+4, stay FETCH.
  - ack, stall_f, no redirect: present the word as above; at edge `hold_instr`<=`imem_rdata`, go HOLD, `pc` unchanged.
  - redirect with ack: drop word (bubble), `pc`<=target, stay FETCH.
  - redirect without ack: `pc`<=target, go DRAIN.
- HOLD: `imem_req`=0; outputs `hold_instr`, `pc`+4, `valid_f`=1. If `stall_f`=0: at edge `pc`<=`pc`+4, go FETCH. If redirect: drop held word, `pc`<=target, go FETCH.
- DRAIN: `imem_req`=1 with `imem_addr` = the address issued before the redirect (captured in a separate `req_addr` register); outputs bubble. On ack: discard data, go FETCH. Further redirect in DRAIN: `pc`<=newest target (latest wins).
- Priority: redirect > stall_f > normal advance.
- `pc`+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- At most one outstanding request; `imem_addr` never changes while `imem_req`=1 and no ack.

## Timing
- Reset (asynchronous, any cycle, including mid-request): state=START, `pc`=`RESET_PC`, `hold_instr`=0; `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_f`=0, `pc_plus4_f`=0, `valid_f`=0. The memory must drop any outstanding request on `rst`.
- First request: cycle after reset release.
- Zero-wait memory (ack in same cycle as req): one instruction per cycle, fetch-to-output latency 0 cycles (combinational from `imem_rdata`).
- Stall entry costs nothing; stall release resumes the request for `pc`+4 in the next cycle (one bubble).
- Redirect penalty: with ack in the redirect cycle, the target request starts the next cycle. In DRAIN, the target request starts the cycle after the discarded ack.

## Structure
- Shared package `fetch_pkg`: state enum (START/FETCH/HOLD/DRAIN), `NOP_INSTR`=32'h0, `WORD_ALIGN_MASK`=32'hFFFF_FFFC.
- Single module; no sub-module. `req_addr` register for DRAIN is internal.

## Test plan
- Reset release, zero-wait memory returning addr-as-data -> `imem_addr` 0,4,8,… on consecutive cycles; `instr_f`=addr, `pc_plus4_f`=addr+4, `valid_f`=1 from cycle 2.
- Ack at addr 8 with `stall_f`=1 for 3 cycles -> `instr_f` held at word(8), `imem_req`=0 during HOLD; next request addr 12 the cycle after `stall_f` falls.
- 3-cycle-latency memory, redirect to 0x100 one cycle after request to 0x20 -> DRAIN; ack for 0x20 discarded (`valid_f`=0); next `imem_addr`=0x100.
- Redirect to 0x203 during HOLD with `stall_f`=1 -> held word dropped, `valid_f`=0, next `imem_addr`=0x200.
- `RESET_PC`=32'hFFFF_FFFC, zero-wait -> `pc_plus4_f`=0, next `imem_addr`=0.
- Assert `rst` while in DRAIN -> all outputs return to reset values immediately; fetch restarts at `RESET_PC` one cycle after release.
